mem_axil_master_bridge: RTL and testbench
=========================================

// Module: mem_axil_master_bridge
// PURPOSE
//  Converts the CPU core's single-outstanding memory request interface into an
//  AXI4-Lite master port. Sits directly downstream of the core, between the
//  core's mem_* bus and the SoC AXI-Lite interconnect.
//  Handles one transaction at a time: a write runs AW/W/B, a read runs AR/R.
//  The AXI response is returned to the core as a one-cycle mem_ready pulse.
// PARAMETERS
//  ADDR_W  32      address width of mem_addr and the AXI address channels
//  DATA_W  32      data width, must be 32; wstrb is DATA_W/8 bits wide
//  PROT    3'b000  constant value driven on awprot and arprot
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        asynchronous, active-low reset
//  mem_addr     in   ADDR_W   request address
//  mem_wdata    in   DATA_W   write data
//  mem_write    in   1        1 = write, 0 = read
//  mem_valid    in   1        request valid; held by the core until mem_ready
//  mem_ready    out  1        one-cycle completion pulse
//  mem_rdata    out  DATA_W   read data; valid while mem_ready is high after a read
//  mem_err      out  1        error flag qualified by mem_ready; 1 = SLVERR/DECERR
//  m_awaddr, m_awprot, m_awvalid (out); m_awready (in)   AXI-Lite AW channel
//  m_wdata, m_wstrb, m_wvalid (out); m_wready (in)       AXI-Lite W channel
//  m_bresp[1:0], m_bvalid (in); m_bready (out)           AXI-Lite B channel
//  m_araddr, m_arprot, m_arvalid (out); m_arready (in)   AXI-Lite AR channel
//  m_rdata, m_rresp[1:0], m_rvalid (in); m_rready (out)  AXI-Lite R channel
// BEHAVIOUR
//  Reset: all outputs are 0 (valids, readies, addresses, data, wstrb,
//   mem_ready, mem_err, mem_rdata); state = IDLE. Asserting reset mid-transaction
//   aborts it immediately. No completion is reported to the core.
//  States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
//  IDLE: if mem_valid=1, latch the request. Address bits [1:0] are forced to 0
//   and wstrb is set to all ones.
//   - mem_write=1: go to WR_ADDR_DATA and raise awvalid and wvalid together.
//   - mem_write=0: go to RD_ADDR and raise arvalid.
//  WR_ADDR_DATA: awvalid drops on the cycle after its own handshake; wvalid
//   likewise. Either handshake may occur first, and neither is ever reissued.
//   When both handshakes are done (same cycle or different cycles), go to WR_RESP.
//  WR_RESP: bready=1. On bvalid, set mem_err = bresp[1] and go to DONE.
//   bready is 0 in every other state.
//  RD_ADDR: arvalid stays high until arready; then go to RD_DATA.
//  RD_DATA: rready=1. On rvalid, capture rdata into mem_rdata, set
//   mem_err = rresp[1], and go to DONE.
//  DONE: mem_ready=1 for exactly this cycle, then go to IDLE.
//   mem_rdata holds its value until the next read completes.
//   mem_err is only meaningful while mem_ready=1.
//  Latency (zero-wait slave): mem_valid sampled at cycle T, channel valids rise
//   at T+1, accepted at T+1, response at T+2, mem_ready at T+3.
//  If the core keeps mem_valid=1 after mem_ready, the next IDLE cycle treats it
//   as a new request; back-to-back transactions are spaced 4 cycles apart.
//  mem_valid dropping or mem_* changing mid-transaction is ignored: the latched
//   request completes and mem_ready still pulses.
//  AXI valid/data signals are never changed while valid=1 and ready=0.
// TESTING
//  1. Write 0xABCD1234 to 0x0, all readies tied 1, bresp=OKAY: AW/W at T+1,
//     mem_ready at T+3 with mem_err=0.
//  2. Write with awready delayed 3 cycles and wready immediate: wvalid drops
//     after 1 cycle, awvalid holds 4 cycles, and no B is accepted before both
//     handshakes complete.
//  3. Read 0x10 with rdata=0x5A5A0001, arready 2 cycles late: mem_rdata=0x5A5A0001
//     while mem_ready=1; value held afterwards.
//  4. Read returning rresp=SLVERR: mem_ready with mem_err=1. A following write
//     with bresp=OKAY reports mem_err=0.
//  5. mem_valid held high continuously with mem_write=1: repeated writes, one
//     mem_ready per transaction, 4-cycle period.
//  6. Assert rst_n=0 while in WR_RESP: all valids/readies are 0 immediately; after
//     release the bridge is in IDLE and a new read completes normally.

Source files
------------

// File: rtl/mem_axil_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mem_axil_master_bridge
// Description : Converts the CPU core's single-outstanding mem_* request bus
//               into an AXI4-Lite master. One transaction is in flight at a
//               time: writes run AW/W/B, reads run AR/R. Completion goes back
//               to the core as a one-cycle mem_ready pulse.
// Ports       : clk, rst_n (async, active-low)
//               core side : mem_addr, mem_wdata, mem_write, mem_valid (in)
//                           mem_ready, mem_rdata, mem_err (out)
//               AXI side  : AW, W, B, AR, R channels of an AXI4-Lite master
// Revision    : 1.0 - initial release
// ============================================================================
module mem_axil_master_bridge #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter logic [2:0]  PROT   = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // core request/response interface
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_write,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    output logic [DATA_W-1:0]     mem_rdata,
    output logic                  mem_err,
    // AXI4-Lite write address channel
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic [2:0]            m_awprot,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    // AXI4-Lite write data channel
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    // AXI4-Lite write response channel
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    // AXI4-Lite read address channel
    output logic [ADDR_W-1:0]     m_araddr,
    output logic [2:0]            m_arprot,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    // AXI4-Lite read data channel
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_WR_ADDR_DATA = 3'd1,
        S_WR_RESP      = 3'd2,
        S_RD_ADDR      = 3'd3,
        S_RD_DATA      = 3'd4,
        S_DONE         = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [ADDR_W-1:0] w_addr_aligned;
    logic              w_aw_done;
    logic              w_w_done;
    logic              w_unused;

    // Accesses are always full-word: the byte offset is discarded.
    assign w_addr_aligned = {mem_addr[ADDR_W-1:2], 2'b00};

    // Only the error bit of the AXI responses matters; OKAY/EXOKAY and
    // SLVERR/DECERR differ in bit 1 alone.
    assign w_unused = ^{mem_addr[1:0], m_bresp[0], m_rresp[0]};

    assign m_awprot = PROT;
    assign m_arprot = PROT;

    // Each valid is cleared after its own handshake, so a low valid inside
    // WR_ADDR_DATA means that channel has already been accepted. A channel
    // accepted in the current cycle counts as done as well.
    assign w_aw_done = ~m_awvalid | m_awready;
    assign w_w_done  = ~m_wvalid  | m_wready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        m_bready     = 1'b0;
        m_rready     = 1'b0;
        mem_ready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_valid) begin
                    w_state_next = mem_write ? S_WR_ADDR_DATA : S_RD_ADDR;
                end
            end
            S_WR_ADDR_DATA: begin
                if (w_aw_done && w_w_done) begin
                    w_state_next = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    w_state_next = S_DONE;
                end
            end
            S_RD_ADDR: begin
                if (m_arready) begin
                    w_state_next = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                m_rready = 1'b1;
                if (m_rvalid) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                mem_ready    = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered AXI request signals and core response
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_awaddr  <= '0;
            m_awvalid <= 1'b0;
            m_wdata   <= '0;
            m_wstrb   <= '0;
            m_wvalid  <= 1'b0;
            m_araddr  <= '0;
            m_arvalid <= 1'b0;
            mem_rdata <= '0;
            mem_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // The request is latched here; later changes on mem_*
                    // have no effect until the bridge returns to IDLE.
                    if (mem_valid) begin
                        if (mem_write) begin
                            m_awaddr  <= w_addr_aligned;
                            m_wdata   <= mem_wdata;
                            m_wstrb   <= '1;
                            m_awvalid <= 1'b1;
                            m_wvalid  <= 1'b1;
                        end else begin
                            m_araddr  <= w_addr_aligned;
                            m_arvalid <= 1'b1;
                        end
                    end
                end
                S_WR_ADDR_DATA: begin
                    // A valid that is already low stays low: neither channel
                    // is ever reissued.
                    if (m_awready) begin
                        m_awvalid <= 1'b0;
                    end
                    if (m_wready) begin
                        m_wvalid <= 1'b0;
                    end
                end
                S_WR_RESP: begin
                    if (m_bvalid) begin
                        mem_err <= m_bresp[1];
                    end
                end
                S_RD_ADDR: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                    end
                end
                S_RD_DATA: begin
                    if (m_rvalid) begin
                        mem_rdata <= m_rdata;
                        mem_err   <= m_rresp[1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_axil_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_axil_master_bridge
// Description : Self-checking bench for mem_axil_master_bridge. A behavioural
//               AXI4-Lite slave with configurable per-channel ready/response
//               delays answers the bridge and records every accepted beat;
//               expected latency, error flag, read data and AXI beats come
//               from a transaction-level model of the bridge's behaviour.
// Ports       : none (top-level bench)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_axil_master_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_valid, mem_ready, mem_err;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;

    always #5 clk = ~clk;

    mem_axil_master_bridge #(.ADDR_W(32), .DATA_W(32), .PROT(3'b000)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_err(mem_err),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // slave configuration (written by the main sequence only)
    int          aw_dly, w_dly, ar_dly, b_dly, r_dly;
    logic [1:0]  cfg_bresp, cfg_rresp;
    logic [31:0] cfg_rdata;

    // beats accepted by the slave
    logic [31:0] aw_q[$];
    logic [35:0] w_q[$];
    logic [31:0] ar_q[$];
    int          aw_len_q[$];
    int          w_len_q[$];
    int          proto_err = 0;

    // model of the value mem_rdata must hold (last completed read)
    logic [31:0] model_rdata;

    // ------------------------------------------------------------------
    // Behavioural AXI4-Lite slave. Acts 1 time unit after each rising edge.
    // ------------------------------------------------------------------
    initial begin : slave
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        bit aw_done, w_done, ar_done, hs_aw, hs_w, hs_b, hs_ar, hs_r;
        bit p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
        logic [31:0] p_awaddr, p_araddr, p_wdata;
        logic [3:0]  p_wstrb;
        m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
        m_bresp = 0; m_rresp = 0; m_rdata = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_done = 0; w_done = 0; ar_done = 0;
        hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
        p_awaddr = 0; p_araddr = 0; p_wdata = 0; p_wstrb = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                aw_done = 0; w_done = 0; ar_done = 0;
                hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
                p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
                m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
            end else begin
                // a pending valid must hold with unchanged payload
                if (p_awv && !p_awr && (m_awvalid !== 1'b1 || m_awaddr !== p_awaddr)) proto_err++;
                if (p_wv && !p_wr && (m_wvalid !== 1'b1 || m_wdata !== p_wdata || m_wstrb !== p_wstrb)) proto_err++;
                if (p_arv && !p_arr && (m_arvalid !== 1'b1 || m_araddr !== p_araddr)) proto_err++;
                // handshakes completed at the edge just passed
                if (hs_aw) begin aw_q.push_back(p_awaddr); aw_len_q.push_back(aw_cnt); aw_done = 1; end
                if (hs_w)  begin w_q.push_back({p_wstrb, p_wdata}); w_len_q.push_back(w_cnt); w_done = 1; end
                if (hs_b)  begin aw_done = 0; w_done = 0; m_bvalid = 0; b_cnt = 0; end
                if (hs_ar) begin ar_q.push_back(p_araddr); ar_done = 1; end
                if (hs_r)  begin ar_done = 0; m_rvalid = 0; r_cnt = 0; end
                // response readiness only once the request side is complete
                if (m_bready === 1'b1 && !(aw_done && w_done)) proto_err++;
                if (m_rready === 1'b1 && !ar_done) proto_err++;
                // request-channel readies after the configured delay
                if (m_awvalid) begin m_awready = (aw_cnt >= aw_dly); aw_cnt++; end
                else begin m_awready = 0; aw_cnt = 0; end
                if (m_wvalid) begin m_wready = (w_cnt >= w_dly); w_cnt++; end
                else begin m_wready = 0; w_cnt = 0; end
                if (m_arvalid) begin m_arready = (ar_cnt >= ar_dly); ar_cnt++; end
                else begin m_arready = 0; ar_cnt = 0; end
                // responses
                if (aw_done && w_done && !m_bvalid) begin
                    if (b_cnt >= b_dly) begin m_bvalid = 1; m_bresp = cfg_bresp; end
                    else b_cnt++;
                end
                if (ar_done && !m_rvalid) begin
                    if (r_cnt >= r_dly) begin m_rvalid = 1; m_rresp = cfg_rresp; m_rdata = cfg_rdata; end
                    else r_cnt++;
                end
                p_awv = m_awvalid; p_awr = m_awready; p_awaddr = m_awaddr;
                p_wv = m_wvalid; p_wr = m_wready; p_wdata = m_wdata; p_wstrb = m_wstrb;
                p_arv = m_arvalid; p_arr = m_arready; p_araddr = m_araddr;
                hs_aw = m_awvalid && m_awready;
                hs_w  = m_wvalid && m_wready;
                hs_b  = m_bvalid && (m_bready === 1'b1);
                hs_ar = m_arvalid && m_arready;
                hs_r  = m_rvalid && (m_rready === 1'b1);
            end
        end
    end

    // Drives one request and waits (bounded) for mem_ready. Called at
    // posedge+2; returns at posedge+2 one cycle after the pulse.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input bit scramble, output int lat, output logic err,
                           output logic [31:0] rd, output logic pulse_one);
        aw_q.delete(); w_q.delete(); ar_q.delete(); aw_len_q.delete(); w_len_q.delete();
        mem_addr = addr; mem_wdata = data; mem_write = wr; mem_valid = 1'b1;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #2;
            if (scramble && i == 1) begin
                mem_valid = 1'b0; mem_addr = $urandom; mem_wdata = $urandom; mem_write = ~wr;
            end
            if (mem_ready === 1'b1) begin lat = i; break; end
        end
        err = mem_err; rd = mem_rdata;
        mem_valid = 1'b0;
        @(posedge clk); #2;
        pulse_one = (mem_ready === 1'b0);
    endtask

    task automatic set_cfg(input int aw, input int w, input int b, input int ar, input int r);
        aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_valid = 0; mem_write = 0; mem_addr = 0; mem_wdata = 0;
        set_cfg(0, 0, 0, 0, 0); cfg_bresp = 0; cfg_rresp = 0; cfg_rdata = 0;
        model_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if ({mem_ready, mem_err, mem_rdata, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
             m_awaddr, m_araddr, m_wdata, m_wstrb} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b err=%b rdata=%h awv=%b wv=%b arv=%b br=%b rr=%b aw=%h ar=%h wd=%h st=%h want all 0",
                     mem_ready, mem_err, mem_rdata, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
                     m_awaddr, m_araddr, m_wdata, m_wstrb);
        end
        n_cmp++;
        if ({m_awprot, m_arprot} !== 6'b0) begin
            n_fail++; $display("FAIL reset_prot: got %b/%b want 000/000", m_awprot, m_arprot);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if ({mem_ready, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== 6'b0) begin
            n_fail++; $display("FAIL idle_after_reset: got %b want 000000",
                               {mem_ready, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready});
        end
    endtask

    task automatic test_write_basic();
        int lat; logic err, pulse; logic [31:0] rd;
        set_cfg(0, 0, 0, 0, 0); cfg_bresp = 2'b00;
        run_txn(1'b1, 32'h0, 32'hABCD1234, 1'b0, lat, err, rd, pulse);
        n_cmp++;
        if (lat !== 3) begin n_fail++; $display("FAIL wr_basic_latency: got %0d want 3", lat); end
        n_cmp++;
        if (err !== 1'b0 || pulse !== 1'b1) begin
            n_fail++; $display("FAIL wr_basic_resp: got err=%b single=%b want 0/1", err, pulse);
        end
        n_cmp++;
        if (aw_q.size() != 1 || aw_q[0] !== 32'h0 || w_q.size() != 1 || w_q[0] !== {4'hF, 32'hABCD1234}) begin
            n_fail++; $display("FAIL wr_basic_beats: got aw=%0d:%h w=%0d:%h want 1:00000000 1:fabcd1234",
                               aw_q.size(), aw_q[0], w_q.size(), w_q[0]);
        end
    endtask

    task automatic test_write_aw_delay();
        int lat; logic err, pulse; logic [31:0] rd;
        set_cfg(3, 0, 0, 0, 0); cfg_bresp = 2'b00;
        run_txn(1'b1, 32'h0000_0104, 32'h1357_9BDF, 1'b0, lat, err, rd, pulse);
        n_cmp++;
        if (lat !== 6) begin n_fail++; $display("FAIL wr_awdly_latency: got %0d want 6", lat); end
        n_cmp++;
        if (aw_len_q.size() != 1 || aw_len_q[0] != 4 || w_len_q.size() != 1 || w_len_q[0] != 1) begin
            n_fail++; $display("FAIL wr_awdly_valid_cycles: got aw=%0d w=%0d want aw=4 w=1",
                               aw_len_q[0], w_len_q[0]);
        end
        n_cmp++;
        if (proto_err != 0) begin n_fail++; $display("FAIL wr_awdly_protocol: got %0d violations want 0", proto_err); end
    endtask

    task automatic test_read_delay();
        int lat; logic err, pulse; logic [31:0] rd;
        set_cfg(0, 0, 0, 2, 0); cfg_rresp = 2'b00; cfg_rdata = 32'h5A5A0001;
        run_txn(1'b0, 32'h10, 32'h0, 1'b0, lat, err, rd, pulse);
        model_rdata = 32'h5A5A0001;
        n_cmp++;
        if (lat !== 5) begin n_fail++; $display("FAIL rd_latency: got %0d want 5", lat); end
        n_cmp++;
        if (rd !== 32'h5A5A0001 || err !== 1'b0) begin
            n_fail++; $display("FAIL rd_data: got %h err=%b want 5a5a0001 err=0", rd, err);
        end
        n_cmp++;
        if (ar_q.size() != 1 || ar_q[0] !== 32'h10) begin
            n_fail++; $display("FAIL rd_araddr: got %0d:%h want 1:00000010", ar_q.size(), ar_q[0]);
        end
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (mem_rdata !== 32'h5A5A0001) begin n_fail++; $display("FAIL rd_hold: got %h want 5a5a0001", mem_rdata); end
    endtask

    task automatic test_error();
        int lat; logic err, pulse; logic [31:0] rd; logic [1:0] resp;
        set_cfg(0, 0, 0, 0, 0);
        for (int r = 0; r < 4; r++) begin
            resp = 2'(r);
            cfg_rresp = resp; cfg_rdata = $urandom;
            run_txn(1'b0, $urandom, 32'h0, 1'b0, lat, err, rd, pulse);
            model_rdata = cfg_rdata;
            n_cmp++;
            if (err !== resp[1] || rd !== model_rdata) begin
                n_fail++; $display("FAIL err_read rresp=%0d: got err=%b rd=%h want err=%b rd=%h", r, err, rd, resp[1], model_rdata);
            end
            cfg_bresp = 2'b00;
            run_txn(1'b1, $urandom, $urandom, 1'b0, lat, err, rd, pulse);
            n_cmp++;
            if (err !== 1'b0) begin n_fail++; $display("FAIL err_write_after_read%0d: got %b want 0", r, err); end
            cfg_bresp = resp;
            run_txn(1'b1, $urandom, $urandom, 1'b0, lat, err, rd, pulse);
            n_cmp++;
            if (err !== resp[1]) begin n_fail++; $display("FAIL err_write bresp=%0d: got %b want %b", r, err, resp[1]); end
        end
    endtask

    task automatic test_scramble();
        int lat; logic err, pulse; logic [31:0] rd;
        set_cfg(1, 2, 1, 0, 0); cfg_bresp = 2'b00;
        run_txn(1'b1, 32'h0000_0027, 32'hC0FF_EE11, 1'b1, lat, err, rd, pulse);
        n_cmp++;
        if (lat !== 6 || pulse !== 1'b1) begin n_fail++; $display("FAIL scramble_latency: got %0d single=%b want 6/1", lat, pulse); end
        n_cmp++;
        if (aw_q.size() != 1 || aw_q[0] !== 32'h24 || w_q.size() != 1 || w_q[0] !== {4'hF, 32'hC0FFEE11} || ar_q.size() != 0) begin
            n_fail++; $display("FAIL scramble_beats: got aw=%h w=%h ar_n=%0d want 00000024 fc0ffee11 0", aw_q[0], w_q[0], ar_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit exp_rdy;
        set_cfg(0, 0, 0, 0, 0); cfg_bresp = 2'b00;
        aw_q.delete(); w_q.delete(); ar_q.delete(); aw_len_q.delete(); w_len_q.delete();
        mem_addr = 32'h0000_0200; mem_wdata = 32'h0F0F_F0F0; mem_write = 1'b1; mem_valid = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #2;
            exp_rdy = (i % 4 == 3);
            n_cmp++;
            if (mem_ready !== exp_rdy) begin
                n_fail++; $display("FAIL b2b_ready cycle %0d: got %b want %b", i, mem_ready, exp_rdy);
            end
        end
        mem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if (aw_q.size() != 5 || w_q.size() != 5) begin
            n_fail++; $display("FAIL b2b_count: got aw=%0d w=%0d want 5/5", aw_q.size(), w_q.size());
        end
    endtask

    task automatic test_random();
        int lat, exp_lat; logic err, pulse, exp_err; logic [31:0] rd, addr, data; bit wr;
        for (int k = 0; k < 24; k++) begin
            wr = ($urandom_range(1, 0) == 1);
            addr = $urandom; data = $urandom;
            set_cfg($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
                    $urandom_range(3, 0), $urandom_range(3, 0));
            cfg_bresp = 2'($urandom_range(3, 0)); cfg_rresp = 2'($urandom_range(3, 0));
            cfg_rdata = $urandom;
            exp_lat = wr ? 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly : 3 + ar_dly + r_dly;
            exp_err = wr ? cfg_bresp[1] : cfg_rresp[1];
            run_txn(wr, addr, data, ($urandom_range(1, 0) == 1), lat, err, rd, pulse);
            if (!wr) model_rdata = cfg_rdata;
            n_cmp++;
            if (lat !== exp_lat || pulse !== 1'b1) begin
                n_fail++; $display("FAIL rand[%0d] latency: got %0d single=%b want %0d/1", k, lat, pulse, exp_lat);
            end
            n_cmp++;
            if (err !== exp_err || rd !== model_rdata) begin
                n_fail++; $display("FAIL rand[%0d] resp: got err=%b rd=%h want err=%b rd=%h", k, err, rd, exp_err, model_rdata);
            end
            n_cmp++;
            if (wr) begin
                if (aw_q.size() != 1 || aw_q[0] !== (addr & 32'hFFFF_FFFC) || w_q.size() != 1 ||
                    w_q[0] !== {4'hF, data} || ar_q.size() != 0 ||
                    aw_len_q[0] != aw_dly + 1 || w_len_q[0] != w_dly + 1) begin
                    n_fail++; $display("FAIL rand[%0d] wr_beats: got aw=%h w=%h ar_n=%0d lens=%0d/%0d want %h %h 0 %0d/%0d",
                                       k, aw_q[0], w_q[0], ar_q.size(), aw_len_q[0], w_len_q[0],
                                       addr & 32'hFFFF_FFFC, {4'hF, data}, aw_dly + 1, w_dly + 1);
                end
            end else begin
                if (ar_q.size() != 1 || ar_q[0] !== (addr & 32'hFFFF_FFFC) || aw_q.size() != 0 || w_q.size() != 0) begin
                    n_fail++; $display("FAIL rand[%0d] rd_beats: got ar=%h n=%0d aw_n=%0d w_n=%0d want %h 1 0 0",
                                       k, ar_q[0], ar_q.size(), aw_q.size(), w_q.size(), addr & 32'hFFFF_FFFC);
                end
            end
        end
        n_cmp++;
        if (proto_err != 0) begin n_fail++; $display("FAIL rand_protocol: got %0d violations want 0", proto_err); end
    endtask

    task automatic test_reset_mid();
        int lat; logic err, pulse; logic [31:0] rd; bit got, quiet;
        set_cfg(0, 0, 6, 0, 0); cfg_bresp = 2'b00;
        mem_addr = 32'h40; mem_wdata = 32'h1111_2222; mem_write = 1'b1; mem_valid = 1'b1;
        got = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #2;
            if (m_bready === 1'b1) begin got = 1; break; end
        end
        mem_valid = 1'b0;
        n_cmp++;
        if (!got) begin n_fail++; $display("FAIL rstmid_reach_wr_resp: got bready never high want high"); end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, mem_ready} !== 6'b0) begin
            n_fail++; $display("FAIL rstmid_async_clear: got %b want 000000",
                               {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, mem_ready});
        end
        quiet = 1;
        repeat (3) begin
            @(posedge clk); #2;
            if (mem_ready !== 1'b0 || m_bready !== 1'b0) quiet = 0;
        end
        rst_n = 1'b1;
        model_rdata = 32'h0;
        @(posedge clk); #2;
        if (mem_ready !== 1'b0 || {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== 5'b0) quiet = 0;
        n_cmp++;
        if (!quiet) begin n_fail++; $display("FAIL rstmid_no_completion: got activity after reset want none"); end
        set_cfg(0, 0, 0, 0, 0); cfg_rresp = 2'b00; cfg_rdata = 32'h600D_F00D;
        run_txn(1'b0, 32'h44, 32'h0, 1'b0, lat, err, rd, pulse);
        model_rdata = cfg_rdata;
        n_cmp++;
        if (lat !== 3 || rd !== 32'h600DF00D || err !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_read_after: got lat=%0d rd=%h err=%b want 3 600df00d 0", lat, rd, err);
        end
    endtask

    initial begin : main
        test_reset();
        test_write_basic();
        test_write_aw_delay();
        test_read_delay();
        test_error();
        test_scramble();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion by 500000 want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
